// File: rtl/dmem_arbiter.sv
// Purpose: round-robin req/gnt arbiter sharing one synchronous data RAM between CPU (A) and loader (B).
// Latency: grant is combinational with req; read data/err return one cycle after acceptance.
// Backpressure: a denied requester holds its request; one transfer accepted per cycle.
// Optional: define DMEM_ARB_PERF_EN to add a_cnt/b_cnt/stall_cnt performance counters.
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 32,
    parameter int DEPTH  = 5300
) (
    input  logic              CLOCK_50,
    input  logic              rstn,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [IDX_W-1:0]  a_idx,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [IDX_W-1:0]  b_idx,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]       a_cnt,
    output logic [31:0]       b_cnt,
    output logic [31:0]       stall_cnt,
`endif
    output logic              ram_wr_en,
    output logic [IDX_W-1:0]  ram_index,
    output logic [DATA_W-1:0] ram_entry,
    input  logic [DATA_W-1:0] ram_entry_out
);

    localparam logic [IDX_W:0] DEPTH_X = (IDX_W+1)'(DEPTH);

    // Round-robin state: 1 means the next tie goes to B. Cleared by reset so
    // the first contended cycle after reset favours the CPU.
    logic              tie_b;
    logic              a_win;
    logic              b_win;
    logic              any_win;
    logic              sel_we;
    logic [IDX_W-1:0]  sel_idx;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;

    // Response pipeline for the access accepted on the previous edge.
    logic              p_vld;
    logic              p_b;
    logic              p_we;
    logic              p_err;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] a_hold;
    logic [DATA_W-1:0] b_hold;

    assign a_win   = rstn & a_req & (~b_req | ~tie_b);
    assign b_win   = rstn & b_req & (~a_req |  tie_b);
    assign any_win = a_win | b_win;
    assign a_gnt   = a_win;
    assign b_gnt   = b_win;

    assign sel_we       = b_win ? b_we    : a_we;
    assign sel_idx      = b_win ? b_idx   : a_idx;
    assign sel_wdata    = b_win ? b_wdata : a_wdata;
    assign sel_in_range = ({1'b0, sel_idx} < DEPTH_X);

    // Idle cycles keep the RAM address/data bus at its last driven value.
    assign ram_index = any_win ? sel_idx   : idx_q;
    assign ram_entry = any_win ? sel_wdata : wdata_q;
    assign ram_wr_en = any_win & sel_we & sel_in_range;

    // Out-of-range reads return zero rather than whatever the RAM presents.
    assign rd_word = p_err ? '0 : ram_entry_out;

    // Responses are gated by rstn so an in-flight read dies as soon as reset asserts.
    assign a_rvalid = rstn & p_vld & ~p_b & ~p_we;
    assign b_rvalid = rstn & p_vld &  p_b & ~p_we;
    assign a_err    = rstn & p_vld & ~p_b & p_err;
    assign b_err    = rstn & p_vld &  p_b & p_err;
    assign a_rdata  = a_rvalid ? rd_word : a_hold;
    assign b_rdata  = b_rvalid ? rd_word : b_hold;

    // Arbitration history and held RAM bus values.
    always_ff @(posedge CLOCK_50) begin
        if (!rstn) begin
            tie_b   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (any_win) begin
            tie_b   <= a_win;
            idx_q   <= sel_idx;
            wdata_q <= sel_wdata;
        end
    end

    // Capture owner/type/range of the accepted access for next-cycle response.
    always_ff @(posedge CLOCK_50) begin
        if (!rstn) begin
            p_vld <= 1'b0;
            p_b   <= 1'b0;
            p_we  <= 1'b0;
            p_err <= 1'b0;
        end else begin
            p_vld <= any_win;
            p_b   <= b_win;
            p_we  <= sel_we;
            p_err <= ~sel_in_range;
        end
    end

    // Read data holders keep rdata stable after the rvalid pulse.
    always_ff @(posedge CLOCK_50) begin
        if (!rstn) begin
            a_hold <= '0;
            b_hold <= '0;
        end else begin
            if (a_rvalid) a_hold <= rd_word;
            if (b_rvalid) b_hold <= rd_word;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    // Per-port accept counters and a per-cycle stall counter, all wrapping.
    always_ff @(posedge CLOCK_50) begin
        if (!rstn) begin
            a_cnt     <= '0;
            b_cnt     <= '0;
            stall_cnt <= '0;
        end else begin
            if (a_win) a_cnt <= a_cnt + 32'd1;
            if (b_win) b_cnt <= b_cnt + 32'd1;
            if ((a_req & ~a_win) | (b_req & ~b_win)) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
